// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] FETCH_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between fetch and decode; flush empties it in one cycle.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wrData,
  output logic [1:0]   count,
  output logic         headValid,
  output fetch_entry_t head
);

  fetch_state_t state, stateNext;
  fetch_entry_t mem [2];
  logic         rdPtr, wrPtr;
  logic         doPush, doPop;

  assign doPush = push & ~flush;
  assign doPop  = pop & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (flush) stateNext = EMPTY;
    else begin
      case (state)
        EMPTY:   if (doPush) stateNext = ONE;
        ONE:     if (doPush && !doPop) stateNext = FULL;
                 else if (doPop && !doPush) stateNext = EMPTY;
        FULL:    if (doPop && !doPush) stateNext = ONE;
        default: stateNext = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr  <= 1'b0;
      wrPtr  <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= wrData;
        wrPtr      <= ~wrPtr;
      end
      if (doPop) rdPtr <= ~rdPtr;
    end
  end

  assign count     = state;
  assign headValid = (state != EMPTY);
  // Stale entries stay in storage after a pop or flush, so mask the head when empty.
  assign head      = headValid ? mem[rdPtr] : '0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, combinational imem read, 2-entry decode buffer, branch redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  input  logic        branchValid,
  input  logic [31:0] branchTarget,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [31:0] instrPc
);

  logic [31:0]  pc;
  logic [1:0]   count;
  logic         push, pop;
  fetch_entry_t wrData, head;

  assign pop  = instrValid & instrReady;
  // A full buffer can still take the new word when decode frees the head this cycle.
  assign push = ~branchValid & ((count != 2'(DEPTH)) | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pc <= RESET_PC;
    else if (branchValid) pc <= {branchTarget[31:2], 2'b00};
    else if (push)        pc <= pc + FETCH_BYTES;
  end

  assign imemAddr     = {2'b00, pc[31:2]};
  assign wrData.pc    = pc;
  assign wrData.instr = imemData;

  fetch_buffer uBuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (branchValid),
    .wrData    (wrData),
    .count     (count),
    .headValid (instrValid),
    .head      (head)
  );

  assign instr   = head.instr;
  assign instrPc = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random ready/redirect traffic vs a queue model.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imemAddr, imemData;
  logic        branchValid = 1'b0;
  logic [31:0] branchTarget = '0;
  logic        instrValid, instrReady = 1'b1;
  logic [31:0] instr, instrPc;

  logic [31:0] wAddr, wData, wInstr, wPc;
  logic        wValid;

  int nCmp = 0, nErr = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] idx);
    return 32'hE000_0000 + idx;
  endfunction

  assign imemData = memWord(imemAddr);
  assign wData    = memWord(wAddr);

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) uDut (
    .clk(clk), .rst_n(rst_n), .imemAddr(imemAddr), .imemData(imemData),
    .branchValid(branchValid), .branchTarget(branchTarget),
    .instrValid(instrValid), .instrReady(instrReady), .instr(instr), .instrPc(instrPc)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) uWrap (
    .clk(clk), .rst_n(rst_n), .imemAddr(wAddr), .imemData(wData),
    .branchValid(1'b0), .branchTarget(32'h0),
    .instrValid(wValid), .instrReady(1'b1), .instr(wInstr), .instrPc(wPc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the buffer is a queue of {pc, instr}; pc advances on every accepted fetch.
  fetch_entry_t q[$];
  logic [31:0]  mPc;

  task automatic modelReset();
    q.delete();
    mPc = 32'h0;
  endtask

  task automatic modelEdge();
    bit took;
    took = (q.size() != 0) && instrReady;
    if (branchValid) begin
      q.delete();
      mPc = branchTarget & 32'hFFFF_FFFC;
    end else begin
      if (took) void'(q.pop_front());
      if (q.size() < 2) begin
        q.push_back('{pc: mPc, instr: memWord(mPc >> 2)});
        mPc = mPc + 32'd4;
      end
    end
  endtask

  task automatic checkOut(input string tag);
    chk({tag, ".valid"}, 32'(instrValid), 32'(q.size() != 0));
    chk({tag, ".instr"}, instr, (q.size() != 0) ? q[0].instr : 32'h0);
    chk({tag, ".pc"}, instrPc, (q.size() != 0) ? q[0].pc : 32'h0);
    chk({tag, ".addr"}, imemAddr, mPc >> 2);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) modelEdge();
    #1;
    checkOut(tag);
  endtask

  initial begin
    modelReset();
    #12;
    checkOut("reset");
    chk("wrap.resetAddr", wAddr, 32'h3FFF_FFFE);
    chk("wrap.resetValid", 32'(wValid), 32'h0);

    @(negedge clk) rst_n = 1'b1;
    step("first");
    chk("first.pc0", instrPc, 32'h0);
    chk("wrap.pc0", wPc, 32'hFFFF_FFF8);
    chk("wrap.instr0", wInstr, 32'hE000_0000 + 32'h3FFF_FFFE);
    step("stream");
    chk("wrap.pc1", wPc, 32'hFFFF_FFFC);
    step("stream");
    chk("wrap.pc2", wPc, 32'h0000_0000);
    for (int i = 0; i < 4; i++) step("stream");

    // Backpressure: fill, hold, then drain in order.
    instrReady = 1'b0;
    for (int i = 0; i < 5; i++) step("stall");
    chk("stall.full", 32'(q.size()), 32'd2);
    instrReady = 1'b1;
    for (int i = 0; i < 4; i++) step("drain");

    // Redirect while FULL to an unaligned target.
    instrReady = 1'b0;
    for (int i = 0; i < 3; i++) step("fill");
    branchValid = 1'b1; branchTarget = 32'h0000_0103;
    step("brFull");
    chk("brFull.valid", 32'(instrValid), 32'h0);
    branchValid = 1'b0;
    step("brFull1");
    chk("brFull.target", instrPc, 32'h0000_0100);
    instrReady = 1'b1;
    step("brFull2");

    // Redirect coinciding with a pop while ONE.
    step("one");
    branchValid = 1'b1; branchTarget = 32'h0000_2000;
    step("brPop");
    chk("brPop.empty", 32'(instrValid), 32'h0);
    branchValid = 1'b0;
    step("brPop1");
    chk("brPop.target", instrPc, 32'h0000_2000);
    step("brPop2");

    // Asynchronous reset while FULL.
    instrReady = 1'b0;
    for (int i = 0; i < 3; i++) step("preRst");
    @(negedge clk) rst_n = 1'b0;
    #1;
    modelReset();
    chk("arst.valid", 32'(instrValid), 32'h0);
    chk("arst.instr", instr, 32'h0);
    chk("arst.pc", instrPc, 32'h0);
    chk("arst.addr", imemAddr, 32'h0);
    step("inRst");
    @(negedge clk) rst_n = 1'b1;
    instrReady = 1'b1;
    step("restart");
    chk("restart.pc0", instrPc, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      instrReady   = ($urandom % 4) != 0;
      branchValid  = ($urandom % 12) == 0;
      branchTarget = $urandom;
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, compared %0d", nCmp);
    $fatal(1);
  end

endmodule
